// File: rtl/ex_alu_unit.sv
// ex_alu_unit: EX-stage ALU with single-cycle ops and an iterative shift-add multiplier.
// Single-cycle ops register their result one cycle after acceptance; MUL holds the
// unit busy (ready_o low) until the product is complete.
// Optional build macro: MUL_RADIX4_EN retires two multiplier bits per cycle instead of one.
module ex_alu_unit #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [SHW-1:0]   shamt_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             busy_o
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SRAV = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_BNE  = 4'b1100;

`ifdef MUL_RADIX4_EN
    localparam int ITER = WIDTH / 2;
`else
    localparam int ITER = WIDTH;
`endif
    localparam logic [SHW-1:0] CNT_LAST = SHW'(ITER - 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_t;

    state_t           state_q;
    logic             ready_q;
    logic             busy_q;
    logic             valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] mul_a_q;
    logic [WIDTH-1:0] mul_b_q;
    logic [WIDTH-1:0] mul_acc_q;

    logic [WIDTH-1:0] alu_res_s;
    logic             alu_zero_s;
    logic             alu_illegal_s;
    logic [WIDTH-1:0] mul_part_s;
    logic [WIDTH-1:0] mul_acc_d;
    logic [WIDTH-1:0] mul_a_d;
    logic [WIDTH-1:0] mul_b_d;

    // Single-cycle datapath: result and branch flag for the presented control code.
    always_comb begin
        alu_res_s     = {WIDTH{1'b0}};
        alu_illegal_s = 1'b0;
        case (ctrl_i)
            OP_ADD:  alu_res_s = src1_i + src2_i;
            OP_SUB:  alu_res_s = src1_i - src2_i;
            OP_AND:  alu_res_s = src1_i & src2_i;
            OP_OR:   alu_res_s = src1_i | src2_i;
            OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OP_SRA:  alu_res_s = $signed(src2_i) >>> shamt_i;
            OP_SRAV: alu_res_s = $signed(src2_i) >>> src1_i[SHW-1:0];
            OP_BNE:  alu_res_s = src1_i - src2_i;
            OP_MUL:  alu_res_s = {WIDTH{1'b0}};
            default: begin
                alu_res_s     = {WIDTH{1'b0}};
                alu_illegal_s = 1'b1;
            end
        endcase
        if (alu_illegal_s) begin
            alu_zero_s = 1'b1;
        end else if (ctrl_i == OP_BNE) begin
            alu_zero_s = (alu_res_s != {WIDTH{1'b0}});
        end else begin
            alu_zero_s = (alu_res_s == {WIDTH{1'b0}});
        end
    end

    // One multiplier iteration: conditional add of the shifted multiplicand.
    always_comb begin
`ifdef MUL_RADIX4_EN
        mul_part_s = (mul_b_q[0] ? mul_a_q : {WIDTH{1'b0}})
                   + (mul_b_q[1] ? {mul_a_q[WIDTH-2:0], 1'b0} : {WIDTH{1'b0}});
        mul_a_d    = {mul_a_q[WIDTH-3:0], 2'b00};
        mul_b_d    = {2'b00, mul_b_q[WIDTH-1:2]};
`else
        mul_part_s = mul_b_q[0] ? mul_a_q : {WIDTH{1'b0}};
        mul_a_d    = {mul_a_q[WIDTH-2:0], 1'b0};
        mul_b_d    = {1'b0, mul_b_q[WIDTH-1:1]};
`endif
        mul_acc_d  = mul_acc_q + mul_part_s;
    end

    // Control FSM with registered handshake, result and multiplier state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= {WIDTH{1'b0}};
            zero_q    <= 1'b0;
            cnt_q     <= {SHW{1'b0}};
            mul_a_q   <= {WIDTH{1'b0}};
            mul_b_q   <= {WIDTH{1'b0}};
            mul_acc_q <= {WIDTH{1'b0}};
        end else begin
            valid_q <= 1'b0;
            if (flush_i) begin
                // Abort wins over any same-cycle request; result/zero keep prior values.
                state_q <= ST_IDLE;
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
                cnt_q   <= {SHW{1'b0}};
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (valid_i && ready_q) begin
                            if (ctrl_i == OP_MUL) begin
                                mul_a_q   <= src1_i;
                                mul_b_q   <= src2_i;
                                mul_acc_q <= {WIDTH{1'b0}};
                                cnt_q     <= {SHW{1'b0}};
                                state_q   <= ST_MUL_RUN;
                                ready_q   <= 1'b0;
                                busy_q    <= 1'b1;
                            end else begin
                                result_q <= alu_res_s;
                                zero_q   <= alu_zero_s;
                                valid_q  <= 1'b1;
                            end
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_MUL_RUN: begin
                        mul_a_q   <= mul_a_d;
                        mul_b_q   <= mul_b_d;
                        mul_acc_q <= mul_acc_d;
                        if (cnt_q == CNT_LAST) begin
                            // Final iteration feeds the output registers directly.
                            result_q <= mul_acc_d;
                            zero_q   <= (mul_acc_d == {WIDTH{1'b0}});
                            valid_q  <= 1'b1;
                            cnt_q    <= {SHW{1'b0}};
                            state_q  <= ST_IDLE;
                            ready_q  <= 1'b1;
                            busy_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + {{(SHW-1){1'b0}}, 1'b1};
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= {SHW{1'b0}};
                    end
                endcase
            end
        end
    end

    assign ready_o  = ready_q;
    assign busy_o   = busy_q;
    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign zero_o   = zero_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Testbench for ex_alu_unit: table-driven single-cycle vectors, MUL/flush/reset
// sequences, and a queue scoreboard checked whenever valid_o pulses.
module tb_ex_alu_unit;

    localparam int W = 32;
`ifdef MUL_RADIX4_EN
    localparam int LAT = W / 2 + 1;
`else
    localparam int LAT = W + 1;
`endif

    localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111, C_SRA = 4'b1000, C_SRAV = 4'b1001;
    localparam logic [3:0] C_MUL = 4'b1011, C_BNE = 4'b1100;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         flush_i = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [3:0]   ctrl_i = 4'b0000;
    logic [W-1:0] src1_i = '0;
    logic [W-1:0] src2_i = '0;
    logic [4:0]   shamt_i = 5'd0;
    logic         valid_o;
    logic [W-1:0] result_o;
    logic         zero_o;
    logic         busy_o;

    ex_alu_unit #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready_o), .ctrl_i(ctrl_i), .src1_i(src1_i), .src2_i(src2_i),
        .shamt_i(shamt_i), .valid_o(valid_o), .result_o(result_o),
        .zero_o(zero_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]   ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [4:0]   sh;
        logic [W-1:0] res;
        logic         zero;
    } vec_t;

    vec_t         tbl[16];
    logic [W:0]   sb_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] last_res;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W:0] model(input logic [3:0] c, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [4:0] sh);
        logic [W-1:0] r;
        logic         z;
        case (c)
            C_ADD:  r = a + b;
            C_SUB:  r = a - b;
            C_AND:  r = a & b;
            C_OR:   r = a | b;
            C_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            C_SRA:  r = $signed(b) >>> sh;
            C_SRAV: r = $signed(b) >>> a[4:0];
            C_BNE:  r = a - b;
            C_MUL:  r = a * b;
            default: r = 32'd0;
        endcase
        if (c == C_BNE) z = (r != 32'd0);
        else if (c inside {C_ADD, C_SUB, C_AND, C_OR, C_SLT, C_SRA, C_SRAV, C_MUL}) z = (r == 32'd0);
        else z = 1'b1;
        return {r, z};
    endfunction

    task automatic send(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] sh, input logic push, input logic [W-1:0] er,
                        input logic ez);
        @(posedge clk_i); #1;
        valid_i = 1'b1; ctrl_i = c; src1_i = a; src2_i = b; shamt_i = sh;
        if (push) begin
            sb_q.push_back({er, ez});
            last_res = er;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
            valid_i = 1'b0;
        end
    endtask

    task automatic mul_check(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] e;
        int cyc;
        e = model(C_MUL, a, b, 5'd0);
        send(C_MUL, a, b, 5'd0, 1'b1, e[W:1], e[0]);
        cyc = 0;
        while (cyc < 3 * LAT) begin
            @(posedge clk_i); #1;
            cyc++;
            if (valid_o) break;
            chk("mul_ready_low", {31'd0, ready_o}, 32'd0);
            // Stray ADD requests while busy must be ignored.
            valid_i = (cyc < LAT - 1) && cyc[0];
            ctrl_i  = C_ADD;
            src1_i  = 32'd1;
            src2_i  = 32'd1;
        end
        valid_i = 1'b0;
        chk("mul_latency", cyc, LAT);
    endtask

    initial begin
        logic [W:0] e;
        logic [3:0] ops[7];
        ops = '{C_ADD, C_SUB, C_SLT, C_AND, C_OR, C_BNE, C_SRA};

        tbl[0]  = '{C_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0};
        tbl[1]  = '{C_SUB,  32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b1};
        tbl[2]  = '{C_AND,  32'hFF00FF00, 32'h0F0F0F0F, 5'd0,  32'h0F000F00, 1'b0};
        tbl[3]  = '{C_OR,   32'hFF00FF00, 32'h0F0F0F0F, 5'd0,  32'hFF0FFF0F, 1'b0};
        tbl[4]  = '{C_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0};
        tbl[5]  = '{C_SLT,  32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000, 1'b1};
        tbl[6]  = '{C_SLT,  32'h80000000, 32'h7FFFFFFF, 5'd0,  32'h00000001, 1'b0};
        tbl[7]  = '{C_SRA,  32'h00000000, 32'h80000000, 5'd4,  32'hF8000000, 1'b0};
        tbl[8]  = '{C_SRA,  32'h00000000, 32'h40000000, 5'd30, 32'h00000001, 1'b0};
        tbl[9]  = '{C_SRAV, 32'h0000001F, 32'h80000000, 5'd0,  32'hFFFFFFFF, 1'b0};
        tbl[10] = '{C_SRAV, 32'h00000024, 32'h00000100, 5'd9,  32'h00000010, 1'b0};
        tbl[11] = '{C_BNE,  32'h00000003, 32'h00000003, 5'd0,  32'h00000000, 1'b0};
        tbl[12] = '{C_BNE,  32'h00000003, 32'h00000004, 5'd0,  32'hFFFFFFFF, 1'b1};
        tbl[13] = '{4'b1111, 32'h00000005, 32'h00000006, 5'd0, 32'h00000000, 1'b1};
        tbl[14] = '{4'b0011, 32'h12345678, 32'h00000001, 5'd0, 32'h00000000, 1'b1};
        tbl[15] = '{C_ADD,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1};
        last_res = 32'd0;

        fork
            // Scoreboard monitor: every valid_o pulse must match the oldest expectation.
            forever begin
                @(negedge clk_i);
                if (rst_i && valid_o) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_valid", {31'd0, valid_o}, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_result", result_o, e[W:1]);
                        chk("sb_zero", {31'd0, zero_o}, {31'd0, e[0]});
                    end
                end
            end
            begin
                #2ms;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        #12;
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_zero", {31'd0, zero_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        // Table vectors, issued back to back
        for (int i = 0; i < 16; i++) begin
            send(tbl[i].ctrl, tbl[i].a, tbl[i].b, tbl[i].sh, 1'b1, tbl[i].res, tbl[i].zero);
        end
        idle(2);

        // Four back-to-back ADDs give four consecutive valid_o pulses
        for (int i = 0; i < 4; i++) begin
            send(C_ADD, 32'(i), 32'd10, 5'd0, 1'b1, 32'(i + 10), 1'b0);
            if (i > 0) chk("b2b_valid", {31'd0, valid_o}, 32'd1);
        end
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        chk("b2b_valid", {31'd0, valid_o}, 32'd1);
        idle(2);

        // Multiplier corner cases
        mul_check(32'hFFFFFFFF, 32'h00000003);
        chk("mul_result", result_o, 32'hFFFFFFFD);
        idle(2);
        mul_check(32'h00010000, 32'h00010000);
        chk("mul_zero", {31'd0, zero_o}, 32'd1);
        idle(2);
        mul_check(32'h00001234, 32'h00005678);
        idle(2);

        // Reset in the middle of a multiply discards it
        send(C_MUL, 32'h00000007, 32'h00000009, 5'd0, 1'b0, 32'd0, 1'b0);
        idle(5);
        rst_i = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, ready_o}, 32'd1);
        chk("midrst_valid", {31'd0, valid_o}, 32'd0);
        chk("midrst_result", result_o, 32'd0);
        chk("midrst_zero", {31'd0, zero_o}, 32'd0);
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        last_res = 32'd0;
        idle(2);
        rst_i = 1'b1;
        idle(LAT + 3);

        // Flush during a multiply: no valid_o, ready returns, result held
        send(C_ADD, 32'd2, 32'd3, 5'd0, 1'b1, 32'd5, 1'b0);
        send(C_MUL, 32'h00000011, 32'h00000022, 5'd0, 1'b0, 32'd0, 1'b0);
        idle(9);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        chk("flush_ready", {31'd0, ready_o}, 32'd1);
        chk("flush_busy", {31'd0, busy_o}, 32'd0);
        idle(LAT + 2);
        chk("flush_hold_result", result_o, last_res);

        // Flush together with valid_i: request is dropped
        @(posedge clk_i); #1;
        flush_i = 1'b1; valid_i = 1'b1; ctrl_i = C_ADD; src1_i = 32'd7; src2_i = 32'd8;
        @(posedge clk_i); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        chk("flush_valid_drop", {31'd0, valid_o}, 32'd0);
        chk("flush_valid_hold", result_o, 32'd5);
        idle(3);

        // Random single-cycle ops and multiplies against the model
        for (int i = 0; i < 12; i++) begin
            logic [3:0]   c;
            logic [W-1:0] a, b;
            logic [4:0]   sh;
            c  = ops[$urandom_range(0, 6)];
            a  = $urandom;
            b  = $urandom;
            sh = 5'($urandom_range(0, 31));
            e  = model(c, a, b, sh);
            send(c, a, b, sh, 1'b1, e[W:1], e[0]);
        end
        idle(2);
        for (int i = 0; i < 3; i++) begin
            mul_check($urandom, $urandom);
            idle(1);
        end
        idle(3);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
